// File: rtl/rx_multipath_mixer.sv
// Receiver front end: packs a serial real sample stream into NUMBER_OF_PATH lanes,
// mixes each lane with its NCO sample (or bypasses), then rounds and saturates.
module rx_multipath_mixer #(
    parameter int NUMBER_OF_PATH = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NCO_WIDTH      = 16,
    parameter int OUT_WIDTH      = 16
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic                                s_valid,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic                                s_align,
    input  logic                                mix_enable,
    input  logic [NCO_WIDTH*NUMBER_OF_PATH-1:0] nco_cos,
    input  logic [NCO_WIDTH*NUMBER_OF_PATH-1:0] nco_sin,
    input  logic                                clear_status,
    output logic                                m_valid,
    output logic [OUT_WIDTH*NUMBER_OF_PATH-1:0] m_i,
    output logic [OUT_WIDTH*NUMBER_OF_PATH-1:0] m_q,
    output logic                                overflow,
    output logic [7:0]                          drop_count
);
    localparam int N  = NUMBER_OF_PATH;
    localparam int IW = $clog2(N);
    localparam int PW = DATA_WIDTH + NCO_WIDTH;
    localparam int RW = (PW + 1 > OUT_WIDTH + 1) ? PW + 1 : OUT_WIDTH + 1;
    localparam int SH = NCO_WIDTH - 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [RW-1:0] ONE  = RW'(1);
    localparam logic signed [RW-1:0] RND  = ONE <<< (NCO_WIDTH - 2);
    localparam logic signed [RW-1:0] OMAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [RW-1:0] OMIN = -OMAX - ONE;

    logic [IW-1:0]                 idx_q, idx_d;
    logic [N-1:0][DATA_WIDTH-1:0]  lane_q, lane_d;
    logic [N-1:0][DATA_WIDTH-1:0]  word_q, word_d;
    logic [N*NCO_WIDTH-1:0]        cos_q, cos_d, sin_q, sin_d;
    logic                          mix_q, mix_d, v1_q, v1_d;
    logic [N-1:0][PW-1:0]          pi_q, pi_d, pq_q, pq_d;
    logic                          v2_q, v2_d;
    logic [N*OUT_WIDTH-1:0]        mi_q, mi_d, mq_q, mq_d;
    logic                          mv_q, mv_d, ovf_q, ovf_d;
    logic [7:0]                    drop_q, drop_d;

    function automatic logic signed [PW-1:0] mul(input logic [DATA_WIDTH-1:0] x,
                                                 input logic [NCO_WIDTH-1:0]  c);
        logic signed [PW-1:0] xe, ce;
        xe = {{NCO_WIDTH{x[DATA_WIDTH-1]}}, x};
        ce = {{DATA_WIDTH{c[NCO_WIDTH-1]}}, c};
        return xe * ce;
    endfunction

    // Bypass is pre-scaled by 2^SH so it shares the mix path's rounding and saturation.
    function automatic logic signed [PW-1:0] bypass(input logic [DATA_WIDTH-1:0] x);
        logic signed [PW-1:0] xe;
        xe = {{NCO_WIDTH{x[DATA_WIDTH-1]}}, x};
        return xe <<< SH;
    endfunction

    // Returns {saturated, value}.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic [PW-1:0] p);
        logic signed [RW-1:0] ext, sh;
        ext = {{(RW - PW){p[PW-1]}}, p};
        sh  = (ext + RND) >>> SH;
        if (sh > OMAX) begin
            return {1'b1, OMAX[OUT_WIDTH-1:0]};
        end else if (sh < OMIN) begin
            return {1'b1, OMIN[OUT_WIDTH-1:0]};
        end else begin
            return {1'b0, sh[OUT_WIDTH-1:0]};
        end
    endfunction

    always_comb begin
        idx_d  = idx_q;
        lane_d = lane_q;
        word_d = word_q;
        cos_d  = cos_q;
        sin_d  = sin_q;
        mix_d  = mix_q;
        v1_d   = 1'b0;
        drop_d = clear_status ? 8'd0 : drop_q;
        if (s_valid) begin
            if (s_align) begin
                lane_d[0] = s_data;
                idx_d     = IW'(1);
                if (idx_q != '0 && drop_d != 8'hFF) begin
                    drop_d = drop_d + 8'd1;
                end
            end else begin
                lane_d[idx_q] = s_data;
                if (idx_q == LAST) begin
                    idx_d          = '0;
                    word_d         = lane_q;
                    word_d[N-1]    = s_data;
                    cos_d          = nco_cos;
                    sin_d          = nco_sin;
                    mix_d          = mix_enable;
                    v1_d           = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end
    end

    always_comb begin
        pi_d = pi_q;
        pq_d = pq_q;
        v2_d = v1_q;
        if (v1_q) begin
            for (int k = 0; k < N; k++) begin
                if (mix_q) begin
                    pi_d[k] = mul(word_q[k], cos_q[k*NCO_WIDTH +: NCO_WIDTH]);
                    pq_d[k] = -mul(word_q[k], sin_q[k*NCO_WIDTH +: NCO_WIDTH]);
                end else begin
                    pi_d[k] = bypass(word_q[k]);
                    pq_d[k] = '0;
                end
            end
        end
    end

    always_comb begin
        logic [OUT_WIDTH:0] ri, rq;
        logic               sat;
        mi_d = mi_q;
        mq_d = mq_q;
        mv_d = v2_q;
        sat  = 1'b0;
        ri   = '0;
        rq   = '0;
        if (v2_q) begin
            for (int k = 0; k < N; k++) begin
                ri = round_sat(pi_q[k]);
                rq = round_sat(pq_q[k]);
                mi_d[k*OUT_WIDTH +: OUT_WIDTH] = ri[OUT_WIDTH-1:0];
                mq_d[k*OUT_WIDTH +: OUT_WIDTH] = rq[OUT_WIDTH-1:0];
                sat = sat | ri[OUT_WIDTH] | rq[OUT_WIDTH];
            end
        end
        ovf_d = (clear_status ? 1'b0 : ovf_q) | sat;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            idx_q  <= '0;
            lane_q <= '0;
            word_q <= '0;
            cos_q  <= '0;
            sin_q  <= '0;
            mix_q  <= 1'b0;
            v1_q   <= 1'b0;
            pi_q   <= '0;
            pq_q   <= '0;
            v2_q   <= 1'b0;
            mi_q   <= '0;
            mq_q   <= '0;
            mv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            idx_q  <= idx_d;
            lane_q <= lane_d;
            word_q <= word_d;
            cos_q  <= cos_d;
            sin_q  <= sin_d;
            mix_q  <= mix_d;
            v1_q   <= v1_d;
            pi_q   <= pi_d;
            pq_q   <= pq_d;
            v2_q   <= v2_d;
            mi_q   <= mi_d;
            mq_q   <= mq_d;
            mv_q   <= mv_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign m_valid    = mv_q;
    assign m_i        = mi_q;
    assign m_q        = mq_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule
